// File: rtl/phase_monitor_4004.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : phase_monitor_4004
// Function : Recovers 4004 instruction-cycle period from clk1/clk2/sync and
//            flags malformed clocking, all in the eclk domain.
// Revision : 1.0
// ============================================================================
module phase_monitor_4004 #(
    parameter int QCYC = 8,
    parameter int CW   = 8
) (
    input  logic       eclk,
    input  logic       ereset,
    input  logic       clk1,
    input  logic       clk2,
    input  logic       sync,
    output logic [2:0] phase,
    output logic       phase_stb,
    output logic       locked,
    output logic [4:0] err
);

    localparam logic [CW-1:0] c_QCYC  = CW'(QCYC);
    localparam logic [CW-1:0] c_STALL = CW'(2 * QCYC);
    localparam logic [CW-1:0] c_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] c_ONE   = CW'(1);
    localparam logic [2:0]    c_X3    = 3'd7;

    localparam int c_ERR_OVL   = 0;
    localparam int c_ERR_WIDTH = 1;
    localparam int c_ERR_ORDER = 2;
    localparam int c_ERR_STALL = 3;
    localparam int c_ERR_SYNC  = 4;

    logic          clk1_q, clk2_q;
    logic          rise1, rise2, fall1, fall2;
    logic [CW-1:0] hi1_q, hi1_d;
    logic [CW-1:0] hi2_q, hi2_d;
    logic [CW-1:0] gap_q, gap_d;
    logic          last_q, last_d;     // 1: clk2 rose most recently
    logic          pend_q, pend_d;
    logic [2:0]    phase_q, phase_d;
    logic          stb_q, stb_d;
    logic          locked_q, locked_d;
    logic [4:0]    err_q, err_d;
    logic [4:0]    err_evt;
    logic          lock_req;

    always_comb begin
        rise1 = clk1 & ~clk1_q;
        rise2 = clk2 & ~clk2_q;
        fall1 = ~clk1 & clk1_q;
        fall2 = ~clk2 & clk2_q;
    end

    // High-width counters: load on the rising edge, saturate while high.
    always_comb begin
        hi1_d = hi1_q;
        if (rise1) begin
            hi1_d = c_ONE;
        end else if (clk1 && (hi1_q != c_MAX)) begin
            hi1_d = hi1_q + c_ONE;
        end

        hi2_d = hi2_q;
        if (rise2) begin
            hi2_d = c_ONE;
        end else if (clk2 && (hi2_q != c_MAX)) begin
            hi2_d = hi2_q + c_ONE;
        end

        gap_d = gap_q;
        if (clk1 || clk2) begin
            gap_d = '0;
        end else if (gap_q != c_MAX) begin
            gap_d = gap_q + c_ONE;
        end
    end

    always_comb begin
        err_evt  = '0;
        last_d   = last_q;
        pend_d   = pend_q;
        phase_d  = phase_q;
        stb_d    = rise1;
        lock_req = 1'b0;

        err_evt[c_ERR_OVL]   = clk1 & clk2;
        err_evt[c_ERR_WIDTH] = (fall1 && (hi1_q != c_QCYC)) ||
                               (fall2 && (hi2_q != c_QCYC));
        // Fires only on the transition into the stall threshold.
        err_evt[c_ERR_STALL] = (gap_d == c_STALL) && (gap_q != c_STALL);

        if (rise1 && rise2) begin
            err_evt[c_ERR_ORDER] = 1'b1;
        end else if (rise1) begin
            err_evt[c_ERR_ORDER] = ~last_q;
            last_d               = 1'b0;
        end else if (rise2) begin
            err_evt[c_ERR_ORDER] = last_q;
            last_d               = 1'b1;
        end

        if (rise1) begin
            if (pend_q) begin
                phase_d  = 3'd0;
                pend_d   = 1'b0;
                lock_req = 1'b1;
                err_evt[c_ERR_SYNC] = locked_q && (phase_q != c_X3);
            end else begin
                phase_d  = phase_q + 3'd1;
                err_evt[c_ERR_SYNC] = locked_q && (phase_q == c_X3);
            end
        end

        // A sync seen at fall2 is consumed by the following rise1.
        if (fall2 && sync) begin
            pend_d = 1'b1;
        end

        err_d    = err_q | err_evt;
        locked_d = locked_q;
        if (|err_evt) begin
            locked_d = 1'b0;
        end else if (lock_req) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            clk1_q   <= 1'b0;
            clk2_q   <= 1'b0;
            hi1_q    <= '0;
            hi2_q    <= '0;
            gap_q    <= '0;
            last_q   <= 1'b1;
            pend_q   <= 1'b0;
            phase_q  <= 3'd0;
            stb_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            clk1_q   <= clk1;
            clk2_q   <= clk2;
            hi1_q    <= hi1_d;
            hi2_q    <= hi2_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            phase_q  <= phase_d;
            stb_q    <= stb_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign phase     = phase_q;
    assign phase_stb = stb_q;
    assign locked    = locked_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_monitor_4004.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_phase_monitor_4004
// Function : Directed stimulus with a strobe-driven scoreboard for
//            phase_monitor_4004.
// Revision : 1.0
// ============================================================================
module tb_phase_monitor_4004;

    logic       eclk = 1'b0;
    logic       ereset;
    logic       clk1;
    logic       clk2;
    logic       sync;
    logic [2:0] phase;
    logic       phase_stb;
    logic       locked;
    logic [4:0] err;

    typedef struct packed {
        logic [2:0] ph;
        logic       lk;
        logic [4:0] er;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    phase_monitor_4004 #(.QCYC(8), .CW(8)) u_dut (
        .eclk      (eclk),
        .ereset    (ereset),
        .clk1      (clk1),
        .clk2      (clk2),
        .sync      (sync),
        .phase     (phase),
        .phase_stb (phase_stb),
        .locked    (locked),
        .err       (err)
    );

    always #5 eclk = ~eclk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int p, input bit l, input int e);
        exp_t x;
        x.ph = 3'(p);
        x.lk = l;
        x.er = 5'(e);
        sb_q.push_back(x);
    endtask

    task automatic seg(input bit c1, input bit c2, input bit s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge eclk);
            clk1 = c1;
            clk2 = c2;
            sync = s;
        end
    endtask

    task automatic period(input int w1, input bit s);
        seg(1'b1, 1'b0, s, w1);
        seg(1'b0, 1'b0, s, 8);
        seg(1'b0, 1'b1, s, 8);
        seg(1'b0, 1'b0, s, 8);
    endtask

    // One nominal period per listed phase; sync is driven during X3.
    task automatic runs(input int first, input int last, input bit l, input int e);
        for (int p = first; p <= last; p++) begin
            push(p, l, e);
            period(8, p == 7);
        end
    endtask

    // Monitor: every strobe consumes one expected entry.
    always @(negedge eclk) begin
        exp_t x;
        if (!ereset && phase_stb) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stb_unexpected: got strobe with phase %0d, expected none", phase);
            end else begin
                x = sb_q.pop_front();
                check("stb_phase",  int'(phase),  int'(x.ph));
                check("stb_locked", int'(locked), int'(x.lk));
                check("stb_err",    int'(err),    int'(x.er));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ereset = 1'b1;
        clk1   = 1'b0;
        clk2   = 1'b0;
        sync   = 1'b0;
        repeat (3) @(negedge eclk);
        check("rst_phase",  int'(phase),     0);
        check("rst_stb",    int'(phase_stb), 0);
        check("rst_locked", int'(locked),    0);
        check("rst_err",    int'(err),       0);
        ereset = 1'b0;
        seg(1'b0, 1'b0, 1'b0, 2);

        // Nominal clocking, lock on first sync, then a full aligned cycle.
        runs(1, 7, 1'b0, 0);
        runs(0, 7, 1'b1, 0);
        runs(0, 0, 1'b1, 0);

        // Short clk1 pulse.
        push(1, 1'b1, 0);
        period(7, 1'b0);
        check("width_err",    int'(err),    5'h02);
        check("width_locked", int'(locked), 0);
        runs(2, 7, 1'b0, 5'h02);
        runs(0, 0, 1'b1, 5'h02);

        // One cycle of overlap as clk2 rises before clk1 falls.
        push(1, 1'b1, 5'h02);
        seg(1'b1, 1'b0, 1'b0, 7);
        seg(1'b1, 1'b1, 1'b0, 1);
        @(posedge eclk);
        #1;
        check("ovl_err",    int'(err),    5'h03);
        check("ovl_locked", int'(locked), 0);
        seg(1'b0, 1'b1, 1'b0, 7);
        seg(1'b0, 1'b0, 1'b0, 8);
        runs(2, 7, 1'b0, 5'h03);
        runs(0, 0, 1'b1, 5'h03);

        // Two clk1 pulses with no clk2 between.
        push(1, 1'b1, 5'h03);
        seg(1'b1, 1'b0, 1'b0, 8);
        seg(1'b0, 1'b0, 1'b0, 8);
        push(2, 1'b0, 5'h07);
        period(8, 1'b0);
        runs(3, 7, 1'b0, 5'h07);
        runs(0, 0, 1'b1, 5'h07);

        // Stall: both clocks low well beyond the threshold.
        push(1, 1'b1, 5'h07);
        period(8, 1'b0);
        seg(1'b0, 1'b0, 1'b0, 16);
        check("stall_err",    int'(err),    5'h0F);
        check("stall_locked", int'(locked), 0);
        runs(2, 7, 1'b0, 5'h0F);
        runs(0, 0, 1'b1, 5'h0F);

        // Sync in the wrong period while locked, then re-lock on X3.
        runs(1, 3, 1'b1, 5'h0F);
        push(4, 1'b1, 5'h0F);
        period(8, 1'b1);
        push(0, 1'b0, 5'h1F);
        period(8, 1'b0);
        runs(1, 7, 1'b0, 5'h1F);
        runs(0, 0, 1'b1, 5'h1F);

        // Asynchronous reset in the middle of a clk1 high phase.
        push(1, 1'b1, 5'h1F);
        seg(1'b1, 1'b0, 1'b0, 4);
        @(negedge eclk);
        ereset = 1'b1;
        #1;
        check("arst_phase",  int'(phase),     0);
        check("arst_stb",    int'(phase_stb), 0);
        check("arst_locked", int'(locked),    0);
        check("arst_err",    int'(err),       0);
        clk1 = 1'b0;
        repeat (2) @(negedge eclk);
        ereset = 1'b0;
        repeat (2) @(negedge eclk);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
